fila_mestre: RTL
================

Name: fila_mestre

Overview:
- Initiator-side controller for the 8-entry byte queue's enqueue/dequeue strobe interface.
- Turns single-cycle push/pop requests from the user logic into correctly timed queue strobes, and holds the queue's write data through the write cycle.
- Captures the popped byte in the single cycle the queue presents it, and rejects operations the queue would refuse (full/empty).
- Sits between the top-level user logic and the queue, in the same 10 kHz clock domain.

Parameters:
- DEPTH, 8, queue capacity; a push is rejected when q_len_in >= DEPTH.
- WIDTH, 8, data width of push/pop data and queue data.

Ports:
- clock_10KHz  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- push_req  input  1  one-cycle push request; sampled only while ready=1.
- pop_req  input  1  one-cycle pop request; sampled only while ready=1.
- push_data  input  WIDTH  byte to push, sampled with push_req.
- q_len_in  input  8  queue occupancy (from queue len_out).
- q_data_in  input  WIDTH  queue data_out.
- enqueue_out  output  1  to queue enqueue_in.
- dequeue_out  output  1  to queue dequeue_in.
- q_data_out  output  WIDTH  to queue data_in.
- ready  output  1  controller idle, will accept a request this cycle.
- pop_valid  output  1  one-cycle pulse: pop_data holds a new popped byte.
- pop_data  output  WIDTH  last popped byte, held until the next pop.
- err_full  output  1  one-cycle pulse: push rejected because the queue is full.
- err_empty  output  1  one-cycle pulse: pop rejected because the queue is empty.
- err_drop  output  1  one-cycle pulse: request lost to arbitration.

Behaviour:
- All outputs and state are registered.
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except ready=1; pop_data=0; q_data_out=0.
- Reset mid-operation aborts the operation: strobes drop immediately, and no pop_valid or err pulse is issued.
- States: IDLE, ENQ_STROBE, ENQ_HOLD, DEQ_STROBE, DEQ_WAIT1, DEQ_WAIT2, DEQ_CAPTURE.
- ready=1 only in IDLE.
- IDLE arbitration, evaluated on each edge:
  - push_req && q_len_in<DEPTH: latch push_data into q_data_out; go to ENQ_STROBE.
  - else if pop_req && q_len_in>0: go to DEQ_STROBE.
  - push_req with queue full: err_full pulses next cycle.
  - pop_req with queue empty: err_empty pulses next cycle.
  - push_req && pop_req with the push served: the pop is discarded and err_drop pulses.
  - push_req && pop_req with queue full: the pop is served and err_full pulses.
- Enqueue path:
  - ENQ_STROBE: enqueue_out=1 for exactly one cycle (cycle T).
  - ENQ_HOLD (T+1): enqueue_out=0; q_data_out held, since the queue writes q_data_in at edge T+2.
  - Return to IDLE at edge T+2.
  - Request-to-ready latency: 3 cycles.
- Dequeue path:
  - DEQ_STROBE: dequeue_out=1 for exactly one cycle (T).
  - DEQ_WAIT1 (T+1): queue removes the head.
  - DEQ_WAIT2 (T+2): queue stages the byte.
  - DEQ_CAPTURE (T+3): q_data_in is valid this cycle only; it is latched into pop_data at edge T+4, pop_valid=1 during T+4, and the state returns to IDLE.
  - Request-to-pop_valid latency: 5 cycles.
- Strobes are never asserted for more than one consecutive cycle, because the queue would re-sample a held strobe.
- q_data_out changes only on an accepted push.
- Requests arriving while ready=0 are ignored silently; no error pulse.
- Occupancy tracking: q_len_in is trusted only in IDLE. In IDLE it is always settled, because the queue updates its length on the same edge the controller returns to IDLE.
- err_* and pop_valid never assert in the same cycle as one another, except err_full with a served pop.

Test Plan:
- Reset: reset=0 mid-DEQ_WAIT1 → enqueue_out=dequeue_out=0, ready=1, pop_valid=0 immediately; no pulse after release.
- Push 0xA5 with q_len_in=0 → enqueue_out high for exactly 1 cycle; q_data_out=0xA5 for 2 cycles; ready returns 3 cycles after request.
- Pop with q_len_in=1, queue model returning 0x3C on q_data_in only in cycle T+3 → pop_data=0x3C, pop_valid=1 for 1 cycle, 5 cycles after request.
- Push with q_len_in=8 → no enqueue_out, err_full=1 for 1 cycle, ready stays 1; pop with q_len_in=0 → err_empty=1, no dequeue_out.
- Simultaneous push_req/pop_req with q_len_in=3 → enqueue performed, err_drop=1; same with q_len_in=8 → dequeue performed, err_full=1.
- Back-to-back: push 0x01..0x08 then 8 pops against a queue model → pop_data sequence 0x01..0x08 in order; 9th pop → err_empty.

Source files
------------

// File: rtl/fila_mestre.sv
// Initiator-side controller for the 8-entry byte queue: turns one-cycle push/pop
// requests into single-cycle enqueue/dequeue strobes and captures popped bytes.
module fila_mestre #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock_10KHz,
    input  logic             reset,
    input  logic             push_req,
    input  logic             pop_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic [7:0]       q_len_in,
    input  logic [WIDTH-1:0] q_data_in,
    output logic             enqueue_out,
    output logic             dequeue_out,
    output logic [WIDTH-1:0] q_data_out,
    output logic             ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             err_full,
    output logic             err_empty,
    output logic             err_drop
);

    typedef enum logic [2:0] {
        IDLE,
        ENQ_STROBE,
        ENQ_HOLD,
        DEQ_STROBE,
        DEQ_WAIT1,
        DEQ_WAIT2,
        DEQ_CAPTURE
    } state_t;

    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    state_t state;
    logic   q_full;
    logic   q_empty;

    // Occupancy is only meaningful in IDLE, which is the only state that reads these.
    assign q_full  = (q_len_in >= DEPTH_L);
    assign q_empty = (q_len_in == 8'd0);

    // NOTE: all state and outputs live in one clocked block and use non-blocking
    // assignments, so every output is a clean register and the update order is irrelevant.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            q_data_out  <= '0;
            ready       <= 1'b1;
            pop_valid   <= 1'b0;
            pop_data    <= '0;
            err_full    <= 1'b0;
            err_empty   <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; a branch raises them for
            // exactly one cycle, which keeps the queue from re-sampling a held strobe.
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            pop_valid   <= 1'b0;
            err_full    <= 1'b0;
            err_empty   <= 1'b0;
            err_drop    <= 1'b0;

            case (state)
                IDLE: begin
                    if (push_req && !q_full) begin
                        q_data_out  <= push_data;
                        enqueue_out <= 1'b1;
                        ready       <= 1'b0;
                        err_drop    <= pop_req;
                        state       <= ENQ_STROBE;
                    end else if (pop_req && !q_empty) begin
                        dequeue_out <= 1'b1;
                        ready       <= 1'b0;
                        err_full    <= push_req;
                        state       <= DEQ_STROBE;
                    end else begin
                        // Any request reaching here was refused by occupancy.
                        err_full  <= push_req;
                        err_empty <= pop_req;
                    end
                end
                ENQ_STROBE: state <= ENQ_HOLD;
                ENQ_HOLD: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                DEQ_STROBE: state <= DEQ_WAIT1;
                DEQ_WAIT1:  state <= DEQ_WAIT2;
                DEQ_WAIT2:  state <= DEQ_CAPTURE;
                DEQ_CAPTURE: begin
                    // The queue presents the popped byte during this cycle only.
                    pop_data  <= q_data_in;
                    pop_valid <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
